// File: rtl/round_pkg.sv
// Shared helpers for the round-robin shared rounder: index widths and saturation constants.
package round_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_pos(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned shift_w(input int unsigned max_shift);
    return clog2(max_shift + 1);
  endfunction

  localparam int unsigned DEF_SHIFT_W = shift_w(16);

endpackage

// File: rtl/round_core.sv
// Combinational variable-shift rounder: round half away from zero, saturating at max positive.
module round_core
  import round_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned OUT_W     = 15,
  parameter  int unsigned MAX_SHIFT = 16,
  localparam int unsigned SW        = shift_w(MAX_SHIFT)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [SW-1:0]    s,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam logic [OUT_W-1:0] MAX_POS = OUT_W'(max_pos(OUT_W));

  logic [OUT_W-1:0] field;
  logic [WIDTH-1:0] lo_mask;
  logic             sign;
  logic             half;
  logic             sticky;
  logic             inc;

  always_comb begin
    field   = OUT_W'(x >> s);
    sign    = field[OUT_W-1];
    half    = 1'b0;
    lo_mask = '0;
    if (s != '0) half = x[s - SW'(1)];
    // bits strictly below the half position; empty when s <= 1
    if (s > SW'(1)) lo_mask = (WIDTH'(1) << (s - SW'(1))) - WIDTH'(1);
    sticky = |(x & lo_mask);
    inc    = half & (~sign | sticky);
    sat    = inc & (field == MAX_POS);
    data   = sat ? MAX_POS : field + OUT_W'(inc);
  end

endmodule

// File: rtl/round_scheduler.sv
// Round-robin arbiter feeding one registered rounding stage, with per-channel shifts and sticky overflow flags.
module round_scheduler
  import round_pkg::*;
#(
  parameter  int unsigned N_CH          = 4,
  parameter  int unsigned WIDTH         = 32,
  parameter  int unsigned OUT_W         = 15,
  parameter  int unsigned MAX_SHIFT     = 16,
  parameter  int unsigned DEFAULT_SHIFT = 16,
  localparam int unsigned CW            = clog2(N_CH),
  localparam int unsigned SW            = shift_w(MAX_SHIFT)
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [N_CH*WIDTH-1:0] req_data,
  output logic [N_CH-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [CW-1:0]         out_chan,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_chan,
  input  logic [SW-1:0]         cfg_shift,
  output logic [N_CH-1:0]       ovf_flags,
  input  logic [N_CH-1:0]       ovf_clr
);

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    ptr_nxt;
  logic [CW-1:0]    gnt_idx;
  logic             any_valid;
  logic             stage_free;
  logic             accept;
  logic [SW-1:0]    shift_q [N_CH];
  logic [SW-1:0]    cur_shift;
  logic [WIDTH-1:0] cur_x;
  logic [OUT_W-1:0] rnd_data;
  logic             rnd_sat;
  logic [N_CH-1:0]  ovf_set;
  logic [SW-1:0]    cfg_clamped;

  // first valid channel at or after ptr, wrapping
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_idx   = ptr;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(ptr) + k) % N_CH;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        gnt_idx   = CW'(idx);
      end
    end
  end

  always_comb begin
    stage_free  = !out_valid || out_ready;
    accept      = any_valid && stage_free;
    req_ready   = accept ? (N_CH'(1) << gnt_idx) : '0;
    cur_x       = req_data[32'(gnt_idx)*WIDTH +: WIDTH];
    cur_shift   = shift_q[gnt_idx];
    ptr_nxt     = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
    ovf_set     = (accept && rnd_sat) ? (N_CH'(1) << gnt_idx) : '0;
    cfg_clamped = (cfg_shift > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : cfg_shift;
  end

  round_core #(
    .WIDTH    (WIDTH),
    .OUT_W    (OUT_W),
    .MAX_SHIFT(MAX_SHIFT)
  ) u_core (
    .x   (cur_x),
    .s   (cur_shift),
    .data(rnd_data),
    .sat (rnd_sat)
  );

  // output stage, pointer and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
      ovf_flags <= '0;
    end else begin
      if (stage_free) out_valid <= accept;
      if (accept) begin
        out_data <= rnd_data;
        out_chan <= gnt_idx;
        ptr      <= ptr_nxt;
      end
      ovf_flags <= (ovf_flags & ~ovf_clr) | ovf_set;
    end
  end

  // shift register file; a write is seen only by later acceptances
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < N_CH; i++) shift_q[i] <= SW'(DEFAULT_SHIFT);
    end else if (cfg_we && (32'(cfg_chan) < N_CH)) begin
      shift_q[cfg_chan] <= cfg_clamped;
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// Scoreboard bench for round_scheduler: directed cases plus random traffic against an arithmetic reference.
module tb_round_scheduler;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned OUT_W     = 15;
  localparam int unsigned MAX_SHIFT = 16;
  localparam int unsigned CW        = 2;
  localparam int unsigned SW        = 5;

  logic                  clk = 1'b0;
  logic                  reset_b;
  logic [N_CH-1:0]       req_valid;
  logic [N_CH*WIDTH-1:0] req_data;
  logic [N_CH-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [CW-1:0]         out_chan;
  logic                  cfg_we;
  logic [CW-1:0]         cfg_chan;
  logic [SW-1:0]         cfg_shift;
  logic [N_CH-1:0]       ovf_flags;
  logic [N_CH-1:0]       ovf_clr;

  always #5 clk = ~clk;

  round_scheduler dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .cfg_we   (cfg_we),
    .cfg_chan (cfg_chan),
    .cfg_shift(cfg_shift),
    .ovf_flags(ovf_flags),
    .ovf_clr  (ovf_clr)
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [CW-1:0]    c;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              failures = 0;
  int              acc_now = 0;
  bit              mon_en = 1'b0;
  int              m_ptr;
  bit              m_ov;
  logic [N_CH-1:0] m_flags;
  int              m_shift [N_CH];
  bit              pend_v [N_CH];
  logic [31:0]     pend_d [N_CH];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // signed value of x[s+OUT_W-1:0], divided by 2^s, rounded half away from zero
  function automatic logic [OUT_W-1:0] ref_round(input logic [31:0] x, input int s, output bit sat);
    longint t, mag, r, lim;
    sat = 1'b0;
    if (s == 0) return x[OUT_W-1:0];
    t = longint'(x) & ((64'sd1 <<< (s + OUT_W)) - 64'sd1);
    if (t >= (64'sd1 <<< (s + OUT_W - 1))) t = t - (64'sd1 <<< (s + OUT_W));
    mag = (t < 0) ? -t : t;
    r   = (mag + (64'sd1 <<< (s - 1))) >>> s;
    if (t < 0) r = -r;
    lim = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    if (r > lim) begin
      sat = 1'b1;
      r   = lim;
    end
    return OUT_W'(r);
  endfunction

  task automatic m_reset();
    m_ptr   = 0;
    m_ov    = 1'b0;
    m_flags = '0;
    for (int i = 0; i < N_CH; i++) m_shift[i] = 16;
    sb.delete();
    acc_now = 0;
  endtask

  task automatic fill(input int ch, input logic [31:0] d);
    pend_v[ch] = 1'b1;
    pend_d[ch] = d;
  endtask

  // one cycle: drive, check combinational/registered state, advance the model, wait for next negedge
  task automatic step();
    int              g;
    bit              sf;
    bit              sat;
    logic [N_CH-1:0] exp_rdy;
    logic [N_CH-1:0] nf;
    exp_t            e;
    for (int i = 0; i < N_CH; i++) begin
      req_valid[i]                = pend_v[i];
      req_data[i*WIDTH +: WIDTH]  = pend_d[i];
    end
    #1;
    chk("ovf_flags", ovf_flags, m_flags);
    chk("out_valid", out_valid, m_ov);
    sf = !m_ov || out_ready;
    g  = -1;
    for (int k = 0; k < N_CH; k++)
      if (g < 0 && pend_v[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
    exp_rdy = '0;
    if (sf && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    acc_now = 0;
    nf = m_flags & ~ovf_clr;
    if (sf && g >= 0) begin
      e.d = ref_round(pend_d[g], m_shift[g], sat);
      e.c = CW'(g);
      sb.push_back(e);
      acc_now = 1;
      if (sat) nf[g] = 1'b1;
      m_ptr = (g + 1) % N_CH;
      pend_v[g] = 1'b0;
    end
    if (sf) m_ov = (g >= 0);
    m_flags = nf;
    if (cfg_we) m_shift[cfg_chan] = (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : int'(cfg_shift);
    @(negedge clk);
    cfg_we  = 1'b0;
    ovf_clr = '0;
  endtask

  task automatic drain();
    int  n;
    bit  busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < 50) begin
      busy = 1'b0;
      for (int i = 0; i < N_CH; i++) if (pend_v[i]) busy = 1'b1;
      if (busy) begin
        step();
        n++;
      end
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending requests not accepted within %0d cycles", n);
    end
  endtask

  task automatic fill_idle_all();
    for (int i = 0; i < N_CH; i++) if (!pend_v[i]) fill(i, $urandom);
  endtask

  function automatic logic [31:0] rand_sample();
    logic [31:0] d;
    case ($urandom % 4)
      0:       d = $urandom;
      1:       d = 32'h3FFF_8000 + ($urandom % 32'h0001_0000);
      2:       d = $urandom & 32'hFFFF_8000;
      default: d = 32'($urandom_range(0, 131071)) - 32'd65536;
    endcase
    return d;
  endfunction

  // monitor: whenever the DUT presents a result, compare with the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset_b && mon_en) begin
        if (out_valid) begin
          if (sb.size() <= acc_now) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output out_chan=%0d out_data=0x%0h with no expected entry", out_chan, out_data);
          end else begin
            chk("out_data", out_data, sb[0].d);
            chk("out_chan", out_chan, sb[0].c);
            if (out_ready) void'(sb.pop_front());
          end
        end else begin
          chk("idle_queue_depth", sb.size(), acc_now);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_b   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_chan  = '0;
    cfg_shift = '0;
    ovf_clr   = '0;
    for (int i = 0; i < N_CH; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
    m_reset();
    @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_chan", out_chan, 0);
    chk("reset_ovf_flags", ovf_flags, 0);
    @(negedge clk);
    reset_b   = 1'b1;
    mon_en    = 1'b1;
    out_ready = 1'b1;

    // rounding corner values at the default shift
    fill(0, 32'h0000_8000); drain();
    fill(0, 32'hFFFF_8000); drain();
    fill(0, 32'hFFFF_8001); drain();
    fill(0, 32'h0001_7FFF); drain();
    step();

    // saturation, clear, and clear racing a new saturation
    fill(0, 32'h3FFF_8000); drain();
    step();
    ovf_clr = 4'b0001; step();
    step();
    fill(0, 32'h3FFF_8000); ovf_clr = 4'b0001; step();
    step();

    // round-robin with all channels requesting, then a lone channel
    repeat (9) begin fill_idle_all(); step(); end
    drain();
    repeat (4) begin fill(2, $urandom); step(); end
    step();

    // backpressure with all channels requesting
    repeat (3) begin fill_idle_all(); step(); end
    out_ready = 1'b0;
    repeat (5) begin fill_idle_all(); step(); end
    out_ready = 1'b1;
    repeat (6) begin fill_idle_all(); step(); end
    drain();
    step();

    // config write racing an acceptance on the same channel, then clamp
    fill(1, 32'h0001_7FFF); cfg_we = 1'b1; cfg_chan = 2'd1; cfg_shift = 5'd8; step();
    fill(1, 32'h0001_7FFF); step();
    fill(1, 32'h0001_7FFF); cfg_we = 1'b1; cfg_chan = 2'd1; cfg_shift = 5'd31; step();
    fill(1, 32'h0001_7FFF); step();
    step();

    // random traffic
    repeat (1500) begin
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N_CH; i++)
        if (!pend_v[i] && ($urandom % 3) != 0) fill(i, rand_sample());
      if (($urandom % 16) == 0) begin
        cfg_we    = 1'b1;
        cfg_chan  = CW'($urandom % N_CH);
        cfg_shift = SW'($urandom % 32);
      end
      if (($urandom % 8) == 0) ovf_clr = N_CH'($urandom);
      step();
    end
    out_ready = 1'b1;
    drain();
    step();

    // reset while a stalled output is held
    cfg_we = 1'b1; cfg_chan = 2'd0; cfg_shift = 5'd16; step();
    fill(0, 32'h3FFF_8000); step();
    out_ready = 1'b0;
    fill(2, 32'h0000_8000); step();
    step();
    #2;
    reset_b = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_out_chan", out_chan, 0);
    chk("midreset_ovf_flags", ovf_flags, 0);
    m_reset();
    for (int i = 0; i < N_CH; i++) pend_v[i] = 1'b0;
    @(negedge clk);
    reset_b   = 1'b1;
    out_ready = 1'b1;
    fill(3, 32'h0000_8000);
    fill(1, 32'h0123_4567);
    drain();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_scheduler.md
# round_scheduler

Shared-rounder scheduler for the multi-channel DSP chain. It arbitrates N_CH sample streams round-robin onto one registered rounding stage. Each channel has its own run-time shift (output LSB position); rounding is round-half-away-from-zero with saturation. The block sits between the per-channel filter/accumulator outputs and the narrow-word output formatter, replacing one fixed-position rounder per channel.

## Interface
- N_CH, 4 — number of requesting channels (2..8)
- WIDTH, 32 — input sample width, two's complement
- OUT_W, 15 — output word width
- MAX_SHIFT, 16 — largest legal shift; MAX_SHIFT+OUT_W <= WIDTH required
- DEFAULT_SHIFT, 16 — per-channel shift after reset
- clk  in  1  clock; one clock domain
- reset_b  in  1  asynchronous, active-low reset
- req_valid  in  N_CH  per-channel sample valid
- req_data  in  N_CH*WIDTH  per-channel samples, channel i at [i*WIDTH +: WIDTH]
- req_ready  out  N_CH  per-channel accept; one-hot or zero
- out_valid  out  1  rounded sample valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  rounded sample
- out_chan  out  clog2(N_CH)  source channel of out_data
- cfg_we  in  1  shift write strobe
- cfg_chan  in  clog2(N_CH)  channel being configured
- cfg_shift  in  clog2(MAX_SHIFT+1)  new shift; values > MAX_SHIFT clamp to MAX_SHIFT
- ovf_flags  out  N_CH  sticky per-channel saturation flags
- ovf_clr  in  N_CH  per-channel flag clear pulses

## Operation
- Handshake on both sides: transfer when valid & ready. Requesters hold valid and data stable until accepted.
- stage_free = !out_valid | out_ready. req_ready[i] = grant[i] & stage_free.
- Arbitration: round-robin pointer ptr, 0 after reset. grant = first channel with req_valid set, searching from ptr upward with wrap. ptr <= granted+1 mod N_CH only on acceptance; otherwise ptr holds.
- Rounding of sample x with shift s (s >= 1):
  - field = x[s+OUT_W-1 : s]; sign = x[s+OUT_W-1]; half = x[s-1]; sticky = |x[s-2:0] (0 when s = 1).
  - inc = (!sign & half) | (sign & half & sticky): ties round away from zero.
  - If inc and field = max positive (0 followed by OUT_W-1 ones): output max positive and set ovf_flags[chan]. Otherwise output field + inc, modulo 2^OUT_W.
  - Bits above s+OUT_W-1 are discarded without saturation.
- s = 0: output x[OUT_W-1:0] truncated, no rounding.
- Config: a cfg_we write takes effect for samples accepted on later cycles. A sample accepted in the same cycle as the write uses the old shift.
- ovf_flags: set by a saturation on acceptance, cleared by ovf_clr[i]. Set and clear in the same cycle: set wins.

## Timing
- Latency 1: a sample accepted at edge n appears on out_valid/out_data/out_chan after edge n.
- Throughput: 1 sample/cycle while out_ready = 1.
- With out_valid = 1 and out_ready = 0: outputs hold stable and all req_ready = 0.
- All outputs registered except req_ready (combinational from req_valid, ptr, out_valid, out_ready).
- Reset values: out_valid 0, out_data 0, out_chan 0, ovf_flags 0, ptr 0, all shifts DEFAULT_SHIFT.
- Reset asserted mid-transfer discards the in-flight output. There is no recovery of the sample.

## Structure
- Shared package/header round_pkg holds:
  - channel-index width function clog2
  - max-positive constant generator for OUT_W
  - shift-width constant
- Sub-module round_core: purely combinational variable-shift rounder (x, s -> data, sat). It is instanced once, ahead of the output register.
- Arbiter, shift register file, output register and flags live in round_scheduler.

## Test plan
- Rounding, ch0, s = 16, OUT_W = 15:
  - 0x0000_8000 -> 0x0001
  - 0xFFFF_8000 -> 0x7FFF (-1)
  - 0xFFFF_8001 -> 0x0000
  - 0x0001_7FFF -> 0x0001
- Saturation: 0x3FFF_8000, s = 16 -> out_data 0x3FFF and ovf_flags[0] = 1. ovf_clr[0] then clears it. Clear in the same cycle as a new saturation leaves the flag at 1.
- Round-robin: all four req_valid held high, out_ready = 1 -> out_chan sequence 0,1,2,3,0,... with one output per cycle. Only ch2 valid -> ch2 accepted every cycle.
- Backpressure: out_ready low for 5 cycles with all channels valid -> out_data/out_chan frozen and req_ready = 0. On release, the order resumes without loss or duplication.
- Config race: cfg_we to ch1 with shift 8 in the same cycle ch1 is accepted -> that sample rounds at s = 16; the next ch1 sample rounds at s = 8. cfg_shift = 31 -> behaves as s = 16.
- Reset: assert reset_b low while out_valid = 1 and out_ready = 0 -> all outputs at reset values and ptr = 0. The first grant after release goes to the lowest-index valid channel.
